// File: rtl/ysyx_22040237_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040237_ctrl_pkg
// Shared definitions for the multi-cycle sequencer: the 3-bit state encoding
// (also exported on state_o for debug), the halt cause codes and a helper
// that identifies the states in which the memory watchdog runs.
// ----------------------------------------------------------------------------
package ysyx_22040237_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_FWAIT  = 3'd2,
      ST_DECODE = 3'd3,
      ST_MEM    = 3'd4,
      ST_MWAIT  = 3'd5,
      ST_WB     = 3'd6,
      ST_HALT   = 3'd7
   } state_e;

   localparam logic [1:0] HALT_NONE    = 2'd0;
   localparam logic [1:0] HALT_EBREAK  = 2'd1;
   localparam logic [1:0] HALT_INVALID = 2'd2;
   localparam logic [1:0] HALT_TMO     = 2'd3;

   // States that wait on a memory handshake and are therefore watched.
   function automatic logic is_wait_state(input state_e s);
      return (s == ST_FETCH) || (s == ST_FWAIT) || (s == ST_MEM) || (s == ST_MWAIT);
   endfunction

endpackage

// File: rtl/ysyx_22040237_tmo_cnt.sv
// ----------------------------------------------------------------------------
// ysyx_22040237_tmo_cnt
// Watchdog counter for the memory handshake states.
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : clear the count (has priority over en_i)
//   en_i      : count this cycle
//   expire_o  : this enabled cycle is the TMO_CYCLES-th consecutive wait cycle
// TMO_CYCLES = 0 disables the watchdog (expire_o tied low).
// ----------------------------------------------------------------------------
module ysyx_22040237_tmo_cnt #(
   parameter int unsigned TMO_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CNT_W = (TMO_CYCLES == 0) ? 1 : $clog2(TMO_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The count holds the number of completed wait cycles, so the cycle that
   // brings it up to TMO_CYCLES is the one where it still reads TMO_CYCLES-1.
   generate
      if (TMO_CYCLES == 0) begin : g_off
         assign expire_o = 1'b0;
      end else begin : g_on
         assign expire_o = en_i && (cnt_q == CNT_W'(TMO_CYCLES - 1));
      end
   endgenerate

endmodule

// File: rtl/ysyx_22040237_mcyc_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22040237_mcyc_ctrl
// Multi-cycle sequencer for the RV64 core:
// IDLE -> FETCH -> FWAIT -> DECODE -> [MEM -> MWAIT] -> WB -> FETCH ...
// with an absorbing HALT on ebreak, invalid instruction or memory timeout.
//   clk, rst                         : clock, synchronous active-high reset
//   imem_req_valid/ready, rsp_valid  : instruction memory handshake
//   dec_*                            : decode flags, sampled in DECODE / WB
//   dmem_req_valid/ready, rsp_valid  : data memory handshake
//   ir_we, pc_we, rf_we              : write-enable gates
//   halt, halt_code                  : stopped flag and cause
//   cycle_cnt, retire_cnt            : 64-bit wrapping counters
//   state_o                          : current state for debug
// ----------------------------------------------------------------------------
module ysyx_22040237_mcyc_ctrl
   import ysyx_22040237_ctrl_pkg::*;
#(
   parameter int unsigned TMO_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic        dec_invalid,
   input  logic        dec_ebreak,
   input  logic        dec_is_load,
   input  logic        dec_is_store,
   input  logic        dec_rd_wr_en,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   input  logic        dmem_rsp_valid,
   output logic        ir_we,
   output logic        pc_we,
   output logic        rf_we,
   output logic        halt,
   output logic [1:0]  halt_code,
   output logic [63:0] cycle_cnt,
   output logic [63:0] retire_cnt,
   output logic [2:0]  state_o
);

   state_e      state_q, state_d;
   logic [1:0]  halt_code_q, halt_code_d;
   logic [63:0] cycle_cnt_q;
   logic [63:0] retire_cnt_q;
   logic        tmo_expire;

   ysyx_22040237_tmo_cnt #(
      .TMO_CYCLES(TMO_CYCLES)
   ) u_tmo (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (state_d != state_q),
      .en_i     (is_wait_state(state_q)),
      .expire_o (tmo_expire)
   );

   // In each waiting state the completing handshake is tested first, so a
   // response landing in the last allowed cycle still wins over the timeout.
   always_comb begin
      state_d        = state_q;
      halt_code_d    = halt_code_q;
      imem_req_valid = 1'b0;
      dmem_req_valid = 1'b0;
      ir_we          = 1'b0;
      pc_we          = 1'b0;
      rf_we          = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) begin
               state_d = ST_FWAIT;
            end else if (tmo_expire) begin
               state_d     = ST_HALT;
               halt_code_d = HALT_TMO;
            end
         end
         ST_FWAIT: begin
            ir_we = imem_rsp_valid;
            if (imem_rsp_valid) begin
               state_d = ST_DECODE;
            end else if (tmo_expire) begin
               state_d     = ST_HALT;
               halt_code_d = HALT_TMO;
            end
         end
         ST_DECODE: begin
            if (dec_invalid) begin
               state_d     = ST_HALT;
               halt_code_d = HALT_INVALID;
            end else if (dec_ebreak) begin
               state_d     = ST_HALT;
               halt_code_d = HALT_EBREAK;
            end else if (dec_is_load || dec_is_store) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            dmem_req_valid = 1'b1;
            if (dmem_req_ready) begin
               state_d = ST_MWAIT;
            end else if (tmo_expire) begin
               state_d     = ST_HALT;
               halt_code_d = HALT_TMO;
            end
         end
         ST_MWAIT: begin
            if (dmem_rsp_valid) begin
               state_d = ST_WB;
            end else if (tmo_expire) begin
               state_d     = ST_HALT;
               halt_code_d = HALT_TMO;
            end
         end
         ST_WB: begin
            pc_we   = 1'b1;
            // Stores carry no rd result even if the decoder flags one.
            rf_we   = dec_rd_wr_en & ~dec_is_store;
            state_d = ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         halt_code_q  <= HALT_NONE;
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         halt_code_q <= halt_code_d;
         if (state_q != ST_HALT) begin
            cycle_cnt_q <= cycle_cnt_q + 64'd1;
         end
         if (state_q == ST_WB) begin
            retire_cnt_q <= retire_cnt_q + 64'd1;
         end
      end
   end

   assign halt       = (state_q == ST_HALT);
   assign halt_code  = halt_code_q;
   assign cycle_cnt  = cycle_cnt_q;
   assign retire_cnt = retire_cnt_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_ysyx_22040237_mcyc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040237_mcyc_ctrl
// Directed bench. Each instruction is described by its class and its wait
// counts; the model expands that into the expected per-cycle trace (phases,
// strobes, counters) and the per-cycle stimulus. The trace is then replayed
// against the DUT, with a few hand-computed counter pins along the way.
// ----------------------------------------------------------------------------
module tb_ysyx_22040237_mcyc_ctrl;
   import ysyx_22040237_ctrl_pkg::*;

   localparam int unsigned TMO = 4;
   localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_EBR = 3, K_INV = 4, K_INVEBR = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic        dec_invalid, dec_ebreak, dec_is_load, dec_is_store, dec_rd_wr_en;
   logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid;
   logic        ir_we, pc_we, rf_we, halt;
   logic [1:0]  halt_code;
   logic [63:0] cycle_cnt, retire_cnt;
   logic [2:0]  state_o;

   always #5 clk = ~clk;

   ysyx_22040237_mcyc_ctrl #(.TMO_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid),
      .dec_invalid(dec_invalid), .dec_ebreak(dec_ebreak), .dec_is_load(dec_is_load),
      .dec_is_store(dec_is_store), .dec_rd_wr_en(dec_rd_wr_en),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_rsp_valid(dmem_rsp_valid),
      .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .halt(halt), .halt_code(halt_code),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .state_o(state_o)
   );

   typedef struct {
      bit          rst, i_rdy, i_rsp, d_rdy, d_rsp;
      bit          f_inv, f_ebr, f_ld, f_st, f_rdw;
      state_e      e_state;
      bit          e_ivld, e_dvld, e_irwe, e_pcwe, e_rfwe, e_halt;
      logic [1:0]  e_code;
      logic [63:0] e_cyc, e_ret;
      bit          pin;
      logic [63:0] pin_cyc, pin_ret;
   } ent_t;

   ent_t        q[$];
   int          total = 0;
   int          bad = 0;
   int          idx = 0;

   // Model state
   logic [63:0] m_cyc = '0, m_ret = '0;
   logic [1:0]  m_code = HALT_NONE;
   bit          c_inv, c_ebr, c_ld, c_st, c_rdw;
   bit          pin_pend = 1'b0;
   logic [63:0] pin_cyc, pin_ret;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle#%0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic pin(input logic [63:0] c, input logic [63:0] r);
      pin_pend = 1'b1;
      pin_cyc  = c;
      pin_ret  = r;
   endtask

   task automatic set_flags(input int kind, input bit rdw);
      c_inv = (kind == K_INV) || (kind == K_INVEBR);
      c_ebr = (kind == K_EBR) || (kind == K_INVEBR);
      c_ld  = (kind == K_LD);
      c_st  = (kind == K_ST);
      c_rdw = rdw;
   endtask

   // One expected cycle: what the outputs must be in phase s, plus the inputs
   // driven during it. Counters advance by the counting rules afterwards.
   task automatic add(input state_e s, input bit r, input bit ir, input bit ip,
                      input bit dr, input bit dp);
      ent_t e;
      e.rst = r; e.i_rdy = ir; e.i_rsp = ip; e.d_rdy = dr; e.d_rsp = dp;
      e.f_inv = c_inv; e.f_ebr = c_ebr; e.f_ld = c_ld; e.f_st = c_st; e.f_rdw = c_rdw;
      e.e_state = s;
      e.e_ivld  = (s == ST_FETCH);
      e.e_dvld  = (s == ST_MEM);
      e.e_irwe  = (s == ST_FWAIT) && ip;
      e.e_pcwe  = (s == ST_WB);
      e.e_rfwe  = (s == ST_WB) && c_rdw && !c_st;
      e.e_halt  = (s == ST_HALT);
      e.e_code  = m_code;
      e.e_cyc   = m_cyc;
      e.e_ret   = m_ret;
      e.pin     = pin_pend; e.pin_cyc = pin_cyc; e.pin_ret = pin_ret;
      pin_pend  = 1'b0;
      q.push_back(e);
      if (r) begin
         m_cyc = '0; m_ret = '0; m_code = HALT_NONE;
      end else begin
         if (s != ST_HALT) m_cyc = m_cyc + 64'd1;
         if (s == ST_WB)   m_ret = m_ret + 64'd1;
      end
   endtask

   // Whole instruction: fw/rw = wait cycles before imem ready/response,
   // mw/dw = wait cycles before dmem ready/response.
   task automatic instr(input int kind, input bit rdw, input int fw, input int rw,
                        input int mw, input int dw);
      set_flags(kind, rdw);
      for (int i = 0; i <= fw; i++) add(ST_FETCH, 1'b0, i == fw, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i <= rw; i++) add(ST_FWAIT, 1'b0, 1'b0, i == rw, 1'b0, 1'b0);
      add(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (c_inv) begin
         m_code = HALT_INVALID;
      end else if (c_ebr) begin
         m_code = HALT_EBREAK;
      end else begin
         if (c_ld || c_st) begin
            for (int i = 0; i <= mw; i++) add(ST_MEM, 1'b0, 1'b0, 1'b0, i == mw, 1'b0);
            for (int i = 0; i <= dw; i++) add(ST_MWAIT, 1'b0, 1'b0, 1'b0, 1'b0, i == dw);
         end
         add(ST_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic halt_for(input int n);
      for (int i = 0; i < n; i++) add(ST_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run();
      ent_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         @(posedge clk);
         #1;
         rst = e.rst; imem_req_ready = e.i_rdy; imem_rsp_valid = e.i_rsp;
         dmem_req_ready = e.d_rdy; dmem_rsp_valid = e.d_rsp;
         dec_invalid = e.f_inv; dec_ebreak = e.f_ebr; dec_is_load = e.f_ld;
         dec_is_store = e.f_st; dec_rd_wr_en = e.f_rdw;
         @(negedge clk);
         chk("state", 64'(state_o), 64'(e.e_state));
         chk("imem_req_valid", 64'(imem_req_valid), 64'(e.e_ivld));
         chk("dmem_req_valid", 64'(dmem_req_valid), 64'(e.e_dvld));
         chk("ir_we", 64'(ir_we), 64'(e.e_irwe));
         chk("pc_we", 64'(pc_we), 64'(e.e_pcwe));
         chk("rf_we", 64'(rf_we), 64'(e.e_rfwe));
         chk("halt", 64'(halt), 64'(e.e_halt));
         chk("halt_code", 64'(halt_code), 64'(e.e_code));
         chk("cycle_cnt", cycle_cnt, e.e_cyc);
         chk("retire_cnt", retire_cnt, e.e_ret);
         if (e.pin) begin
            chk("pin_cycle_cnt", cycle_cnt, e.pin_cyc);
            chk("pin_retire_cnt", retire_cnt, e.pin_ret);
         end
         $display("cycle#%0d st=%0d ivld=%0b dvld=%0b irwe=%0b pcwe=%0b rfwe=%0b halt=%0b code=%0d cyc=%0d ret=%0d",
                  idx, state_o, imem_req_valid, dmem_req_valid, ir_we, pc_we, rf_we,
                  halt, halt_code, cycle_cnt, retire_cnt);
         idx++;
      end
   endtask

   initial begin
      imem_req_ready = 0; imem_rsp_valid = 0; dmem_req_ready = 0; dmem_rsp_valid = 0;
      dec_invalid = 0; dec_ebreak = 0; dec_is_load = 0; dec_is_store = 0; dec_rd_wr_en = 0;
      set_flags(K_ALU, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      // Reset state, hand-written
      chk("rst_state", 64'(state_o), 64'd0);
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_code", 64'(halt_code), 64'd0);
      chk("rst_cycle", cycle_cnt, 64'd0);
      chk("rst_retire", retire_cnt, 64'd0);
      chk("rst_strobes", 64'({imem_req_valid, dmem_req_valid, ir_we, pc_we, rf_we}), 64'd0);

      // addi with zero-wait memory, then load / store / slow ALU
      add(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      instr(K_ALU, 1'b1, 0, 0, 0, 0);
      pin(64'd5, 64'd1);
      instr(K_LD, 1'b1, 0, 0, 3, 1);
      pin(64'd15, 64'd2);
      instr(K_ST, 1'b1, 0, 0, 0, 0);
      pin(64'd21, 64'd3);
      instr(K_ALU, 1'b0, 2, 3, 0, 0);   // response in the 4th FWAIT cycle
      pin(64'd30, 64'd4);

      // Fetch response never arrives: timeout after 4 FWAIT cycles
      set_flags(K_ALU, 1'b0);
      add(ST_FETCH, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) add(ST_FWAIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      m_code = HALT_TMO;
      pin(64'd35, 64'd4);
      halt_for(3);
      add(ST_HALT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset in MWAIT with a stale response one cycle later
      add(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_flags(K_LD, 1'b1);
      add(ST_FETCH, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(ST_FWAIT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(ST_MEM, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(ST_MWAIT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      pin(64'd0, 64'd0);
      add(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      instr(K_ALU, 1'b1, 0, 0, 0, 0);

      // ebreak: halt code 1, counters frozen for 21 cycles
      instr(K_EBR, 1'b1, 0, 0, 0, 0);
      pin(64'd8, 64'd1);
      halt_for(21);
      add(ST_HALT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // invalid together with ebreak: invalid wins
      add(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      instr(K_INVEBR, 1'b1, 0, 0, 0, 0);
      pin(64'd4, 64'd0);
      halt_for(3);
      add(ST_HALT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Fetch request never accepted: timeout after 4 FETCH cycles
      add(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_flags(K_ALU, 1'b0);
      for (int i = 0; i < 4; i++) add(ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      m_code = HALT_TMO;
      pin(64'd5, 64'd0);
      halt_for(2);

      run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
